calc_decimal: RTL and testbench



---
 rtl/calc_decimal.sv | 109 ++++++++++
 tb/tb_calc_decimal.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/calc_decimal.sv
// Bit-serial restoring divider returning frac(N/D) as a W-bit unsigned binary fraction.
// Latency: 2W cycles from the accepting edge to the one-cycle done pulse.
// Backpressure: none; start is only sampled in IDLE, and a start seen while BUSY is dropped.
module calc_decimal #(
  parameter int P_WIDTH_IN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [P_WIDTH_IN-1:0] numerator_in,
  input  logic [P_WIDTH_IN-1:0] denominator_in,
  output logic                  done,
  output logic [P_WIDTH_IN-1:0] decimal_out
);

  localparam int W     = P_WIDTH_IN;
  localparam int STEPS = 2 * W;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Dividend shift register {N, W'b0}. Quotient bits are shifted in at the
  // LSB as dividend bits leave at the MSB, so after 2W steps it holds the
  // full 2W-bit quotient.
  logic [2*W-1:0]   dvd_q, dvd_d;
  logic [W:0]       rem_q, rem_d;
  logic [W-1:0]     den_q, den_d;
  logic             done_q, done_d;
  logic [W-1:0]     dec_q, dec_d;

  logic [W+1:0]     rem_shift;
  logic             q_bit;

  // One restoring-division step: shift in the next dividend bit and trial-compare against D.
  // With D = 0 the compare is always true, so every quotient bit is 1 and the
  // result comes out all ones without a special case.
  always_comb begin
    rem_shift = {rem_q, dvd_q[2*W-1]};
    q_bit     = (rem_shift >= {2'b00, den_q});
  end

  // Next-state and datapath update for the IDLE/BUSY sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    den_d   = den_q;
    done_d  = 1'b0;
    dec_d   = dec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          dvd_d   = {numerator_in, {W{1'b0}}};
          rem_d   = '0;
          den_d   = denominator_in;
        end
      end
      S_BUSY: begin
        rem_d = q_bit ? (rem_shift[W:0] - {1'b0, den_q}) : rem_shift[W:0];
        dvd_d = {dvd_q[2*W-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Only the low W quotient bits are kept; the integer part is dropped.
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          dec_d   = {dvd_q[W-2:0], q_bit};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      done_q  <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      done_q  <= done_d;
      dec_q   <= dec_d;
    end
  end

  assign done        = done_q;
  assign decimal_out = dec_q;

endmodule

// File: tb/tb_calc_decimal.sv
// Directed bench for calc_decimal (W = 16): ratios, partial sweep, divide by zero, protocol, reset.
// Latency: each request is expected to complete 32 edges after acceptance.
// Backpressure: none; start is pulsed for one cycle per request.
module tb_calc_decimal;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] numerator_in;
  logic [15:0] denominator_in;
  logic        done;
  logic [15:0] decimal_out;

  int checks;
  int passes;

  calc_decimal #(.P_WIDTH_IN(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .numerator_in   (numerator_in),
    .denominator_in (denominator_in),
    .done           (done),
    .decimal_out    (decimal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; the request is accepted on the posedge inside.
  task automatic issue(input logic [15:0] n, input logic [15:0] d);
    @(negedge clk);
    numerator_in   = n;
    denominator_in = d;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (sampled 1 time unit after each edge); 0 if it never came.
  task automatic wait_done(input int limit, output int edges);
    edges = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = i;
        break;
      end
    end
  endtask

  // Count done pulses over a window of edges.
  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] n, input logic [15:0] d,
                       input logic [15:0] exp);
    int lat;
    issue(n, d);
    wait_done(40, lat);
    check({tag, " latency"}, lat, 32);
    check({tag, " value"}, decimal_out, exp);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] exp;
    checks         = 0;
    passes         = 0;
    rst_n          = 1'b0;
    start          = 1'b0;
    numerator_in   = '0;
    denominator_in = '0;

    // Reset state before any clock edge.
    #2;
    check("reset done", done, 1'b0);
    check("reset value", decimal_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ratios.
    do_op("1/2",     16'd1,   16'd2,   16'h8000);
    do_op("1/3",     16'd1,   16'd3,   16'h5555);
    do_op("2/3",     16'd2,   16'd3,   16'hAAAA);
    do_op("1/255",   16'd1,   16'd255, 16'h0101);
    do_op("254/255", 16'd254, 16'd255, 16'hFEFE);

    // Integer part discarded, exact integers, divide by zero, full-range operands.
    do_op("5/4",     16'd5,     16'd4,     16'h4000);
    do_op("7/7",     16'd7,     16'd7,     16'h0000);
    do_op("3/0",     16'd3,     16'd0,     16'hFFFF);
    do_op("ffff/fffe", 16'hFFFF, 16'hFFFE, 16'h0001);
    do_op("fffe/ffff", 16'hFFFE, 16'hFFFF, 16'hFFFE);

    // Sweep: all N < D for small D, plus a strided sweep at D = 255.
    for (int d = 1; d <= 20; d++) begin
      for (int n = 1; n < d; n++) begin
        exp = (32'(n) * 32'd65536) / 32'(d);
        do_op("sweep", 16'(n), 16'(d), exp[15:0]);
      end
    end
    for (int n = 1; n < 255; n += 23) begin
      exp = (32'(n) * 32'd65536) / 32'd255;
      do_op("sweep255", 16'(n), 16'd255, exp[15:0]);
    end

    // start re-asserted while BUSY with different operands: ignored.
    issue(16'd1, 16'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start          = 1'b1;
      numerator_in   = 16'd2;
      denominator_in = 16'd7;
    end
    @(negedge clk);
    start = 1'b0;
    // Edges k+1..k+5 have passed, so done is due 27 edges later.
    wait_done(40, lat);
    check("busy_start latency", lat, 27);
    check("busy_start value", decimal_out, 16'h5555);
    count_done(40, pulses);
    check("busy_start single done", pulses, 0);

    // Back-to-back: start presented on the edge right after done.
    issue(16'd1, 16'd2);
    wait_done(40, lat);
    check("b2b first latency", lat, 32);
    check("b2b first value", decimal_out, 16'h8000);
    numerator_in   = 16'd2;
    denominator_in = 16'd3;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b done low", done, 1'b0);
    check("b2b hold value", decimal_out, 16'h8000);
    wait_done(40, lat);
    check("b2b second latency", lat, 32);
    check("b2b second value", decimal_out, 16'hAAAA);

    // Reset at iteration 10 of an operation.
    issue(16'd1, 16'd3);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset done", done, 1'b0);
    check("midreset value", decimal_out, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, pulses);
    check("midreset no done", pulses, 0);
    check("midreset value held", decimal_out, 16'h0000);
    do_op("after_reset 2/3", 16'd2, 16'd3, 16'hAAAA);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
